// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I datapath: sequences fetch, decode, memory,
// ALU and control-flow steps and drives the datapath selects and write enables.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       LessThan,
  input  logic       LessThanUnsigned,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       illegal_instr,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1001;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;
  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;
  localparam logic [SEL_W-1:0] IMM_I      = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S      = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B      = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J      = 2'b11;

  state_t state_q;
  state_t state_d;

  // funct3/funct7b5 to ALU operation; only register-register ops honour SUB
  function automatic logic [ALU_W-1:0] alu_decode(input logic [2:0] f3,
                                                  input logic       f7b5,
                                                  input logic       is_r);
    logic [ALU_W-1:0] code;
    code = ALU_ADD;
    case (f3)
      3'b000:  code = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  // Datapath controls per state; write enables and illegal_instr are
  // suppressed during reset so an abandoned access never commits
  always_comb begin
    PCWrite       = 1'b0;
    IRWrite       = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    ALUControl    = ALU_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR: illegal_instr = 1'b0;
          default: illegal_instr = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = alu_decode(funct3, funct7b5, 1'b1);
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_decode(funct3, funct7b5, 1'b0);
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_SUB;
        case (funct3)
          3'b000:        PCWrite = Zero;
          3'b001:        PCWrite = ~Zero;
          3'b100:        PCWrite = LessThan;
          3'b101:        PCWrite = ~LessThan;
          3'b110:        PCWrite = LessThanUnsigned;
          3'b111:        PCWrite = ~LessThanUnsigned;
          default:       illegal_instr = 1'b1;
        endcase
      end
      S_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      PCWrite       = 1'b0;
      IRWrite       = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized check of multicycle_controller against a path-per-instruction-class
// reference model, plus directed instructions and a mid-store reset.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, LessThan, LessThanUnsigned;
  logic       mem_ready;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;
  logic       illegal_instr;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LessThan(LessThan), .LessThanUnsigned(LessThanUnsigned),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  logic [17:0] ctrl;
  assign ctrl = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
                 ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction classes: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 jal, 6 jalr, 7 illegal
  function automatic int cls(input logic [6:0] o);
    case (o)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      7'b1100111: return 6;
      default:    return 7;
    endcase
  endfunction

  // Cycle count of each class with memory always ready
  function automatic int latency(input int c);
    case (c)
      0, 1, 3, 5: return 4;
      2, 6:       return 5;
      4:          return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic bit is_wait(input int st);
    return st == 0 || st == 3 || st == 5;
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input bit r);
    case (f3)
      3'd0: return (r && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [17:0] exp_ctrl(input int st, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7,
                                            input logic z, input logic lt,
                                            input logic ltu, input logic mr);
    logic pcw, irw, mw, rw, adr, ill;
    logic [1:0] rs, a, b, imm;
    logic [3:0] alu;
    int c;
    c = cls(o);
    {pcw, irw, mw, rw, adr, ill} = '0;
    rs = 2'd0; a = 2'd0; b = 2'd0; alu = 4'd0;
    imm = (c == 3) ? 2'd1 : (c == 4) ? 2'd2 : (c == 5) ? 2'd3 : 2'd0;
    case (st)
      0:  begin b = 2'd2; rs = 2'd2; irw = mr; pcw = mr; end
      1:  begin a = 2'd1; b = 2'd1; ill = (c == 7); end
      2:  begin a = 2'd2; b = 2'd1; end
      3:  adr = 1'b1;
      4:  begin rs = 2'd1; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; end
      6:  begin a = 2'd2; alu = alu_of(f3, f7, 1'b1); end
      7:  begin a = 2'd2; b = 2'd1; alu = alu_of(f3, f7, 1'b0); end
      8:  rw = 1'b1;
      9:  begin
        a = 2'd2; alu = 4'd1;
        case (f3)
          3'd0: pcw = z;
          3'd1: pcw = !z;
          3'd4: pcw = lt;
          3'd5: pcw = !lt;
          3'd6: pcw = ltu;
          3'd7: pcw = !ltu;
          default: ill = 1'b1;
        endcase
      end
      10: begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
      11: begin a = 2'd2; b = 2'd1; end
      default: ;
    endcase
    return {pcw, irw, mw, rw, adr, rs, a, b, imm, alu, ill};
  endfunction

  // Runs one instruction from FETCH; entered and left 1 time unit after a rising edge.
  // stall<0: random mem_ready; stall>=0: that many not-ready cycles in MEMREAD/MEMWRITE.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int stall, input bit rnd_flags,
                           input logic zf, input logic ltf, input logic ltuf);
    int path[8];
    int len, idx, cyc, waits, c;
    c = cls(o);
    path[0] = 0; path[1] = 1; len = 2;
    case (c)
      0: begin path[2] = 6;  path[3] = 8; len = 4; end
      1: begin path[2] = 7;  path[3] = 8; len = 4; end
      2: begin path[2] = 2;  path[3] = 3; path[4] = 4; len = 5; end
      3: begin path[2] = 2;  path[3] = 5; len = 4; end
      4: begin path[2] = 9;  len = 3; end
      5: begin path[2] = 10; path[3] = 8; len = 4; end
      6: begin path[2] = 11; path[3] = 10; path[4] = 8; len = 5; end
      default: len = 2;
    endcase
    op = o; funct3 = f3; funct7b5 = f7;
    idx = 0; cyc = 0; waits = 0;
    while (idx < len) begin
      if (rnd_flags) {Zero, LessThan, LessThanUnsigned} = 3'($urandom);
      else           {Zero, LessThan, LessThanUnsigned} = {zf, ltf, ltuf};
      if (stall < 0)                      mem_ready = ($urandom % 4) != 0;
      else if (path[idx] == 3 || path[idx] == 5) mem_ready = (waits >= stall);
      else                                mem_ready = 1'b1;
      @(negedge clk);
      check($sformatf("state_c%0d", c), 32'(state), 32'(path[idx]));
      check($sformatf("ctrl_c%0d_s%0d", c, path[idx]), 32'(ctrl),
            32'(exp_ctrl(path[idx], o, f3, f7, Zero, LessThan, LessThanUnsigned, mem_ready)));
      if (is_wait(path[idx]) && !mem_ready) waits++;
      else begin idx++; waits = 0; end
      cyc++;
      @(posedge clk); #1;
    end
    if (stall == 0) check($sformatf("latency_c%0d", c), 32'(cyc), 32'(latency(c)));
  endtask

  logic [6:0] ops [8];

  initial begin
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111; ops[7] = 7'b0110111;
    reset = 1'b0; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
    {Zero, LessThan, LessThanUnsigned} = 3'b000; mem_ready = 1'b1;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_we", 32'({PCWrite, IRWrite, MemWrite, RegWrite, illegal_instr}), 32'd0);
    @(posedge clk); #1;
    check("rst_hold", 32'(state), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    run_instr(7'b0110011, 3'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // add
    run_instr(7'b0000011, 3'd2, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0);  // lw, 3 stalls
    run_instr(7'b1100011, 3'd6, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);  // bltu taken
    run_instr(7'b1100011, 3'd6, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);  // bltu not taken
    run_instr(7'b1100111, 3'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // jalr
    run_instr(7'b0110111, 3'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // lui: illegal
    run_instr(7'b0100011, 3'd2, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);  // sw, 2 stalls
    run_instr(7'b0100011, 3'd2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // sw
    run_instr(7'b0000011, 3'd2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // lw
    run_instr(7'b1101111, 3'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // jal
    run_instr(7'b0010011, 3'd0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // addi, f7b5 ignored
    run_instr(7'b0110011, 3'd0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // sub
    run_instr(7'b0010011, 3'd5, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // srai
    run_instr(7'b1100011, 3'd2, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);  // bad branch funct3

    for (int i = 0; i < 300; i++) begin
      logic [6:0] o;
      if ($urandom % 6 == 0) o = 7'($urandom);
      else                   o = ops[$urandom % 8];
      run_instr(o, 3'($urandom), 1'($urandom), -1, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Reset while a store is stalled in MEMWRITE
    op = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("mw_state", 32'(state), 32'd5);
    check("mw_memwrite", 32'(MemWrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mw_rst_state", 32'(state), 32'd0);
    check("mw_rst_memwrite", 32'(MemWrite), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("mw_rst_we", 32'({PCWrite, IRWrite, MemWrite, RegWrite, illegal_instr}), 32'd0);
    @(posedge clk); #1;
    check("mw_rst_hold", 32'(state), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_stall1", 32'(state), 32'd0);
    @(negedge clk);
    check("post_rst_irwrite0", 32'({PCWrite, IRWrite}), 32'd0);
    @(posedge clk); #1;
    check("post_rst_stall2", 32'(state), 32'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    check("post_rst_irwrite1", 32'({PCWrite, IRWrite}), 32'd3);
    @(posedge clk); #1;
    check("post_rst_decode", 32'(state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
